sync_fifo: RTL and testbench

- Single-clock first-word-fall-through FIFO buffering DSIZE-bit words, depth 2^ASIZE.
- Storage is a dual-port register array indexed by binary read/write pointers.
- Producer pushes with winc, gated by wfull. Consumer pops with rinc, gated by rempty.
- Instantiated as the FIFO stage of the bridge datapath. Ports keep the w*/r* naming of the producer and consumer sides.

---
 rtl/sync_fifo_if.sv | 22 ++
 rtl/sync_fifo.sv | 59 +++++
 tb/tb_sync_fifo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo; the FIFO takes the slave side,
// the block feeding and draining it takes the master side.
interface sync_fifo_if #(
    parameter int DSIZE = 8
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;

    modport master (
        output winc, wdata, rinc,
        input  rdata, wfull, rempty
    );

    modport slave (
        input  winc, wdata, rinc,
        output rdata, wfull, rempty
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO, depth 2^ASIZE, with exact registered
// full/empty flags derived from the next-state pointers.
module sync_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    logic [ASIZE:0] waddr_q, waddr_d;
    logic [ASIZE:0] raddr_q, raddr_d;
    logic           wfull_q, wfull_d;
    logic           rempty_q, rempty_d;
    logic           w_en, r_en;

    always_comb begin
        w_en     = bus.winc && !wfull_q && rst_n;
        r_en     = bus.rinc && !rempty_q && rst_n;
        waddr_d  = waddr_q + {{ASIZE{1'b0}}, w_en};
        raddr_d  = raddr_q + {{ASIZE{1'b0}}, r_en};
        rempty_d = (raddr_d == waddr_d);
        wfull_d  = (waddr_d[ASIZE] != raddr_d[ASIZE]) &&
                   (waddr_d[ASIZE-1:0] == raddr_d[ASIZE-1:0]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the asynchronous reset clears pointers and flags at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q  <= '0;
            raddr_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
        end else begin
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers already discards
    // its contents and a reset port would prevent mapping it onto RAM.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[waddr_q[ASIZE-1:0]] <= bus.wdata;
        end
    end

    assign bus.rdata  = mem[raddr_q[ASIZE-1:0]];
    assign bus.wfull  = wfull_q;
    assign bus.rempty = rempty_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue models the FIFO contents, and pops, head
// word and both flags are compared against it every cycle.
module tb_sync_fifo;
    localparam int DSIZE = 6;
    localparam int ASIZE = 4;
    localparam int DEPTH = 1 << ASIZE;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sync_fifo_if #(.DSIZE(DSIZE)) bus ();

    sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    logic [DSIZE-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_rempty"}, 32'(bus.rempty), 32'(exp_q.size() == 0));
        check({tag, "_wfull"},  32'(bus.wfull),  32'(exp_q.size() == DEPTH));
        if (exp_q.size() != 0) begin
            check({tag, "_head"}, 32'(bus.rdata), 32'(exp_q[0]));
        end
    endtask

    // Called just after a falling edge: drive, cross one rising edge, then check.
    task automatic step(input logic w, input logic [DSIZE-1:0] d, input logic r,
                        input string tag);
        bit do_w, do_r;
        bus.winc  = w;
        bus.wdata = d;
        bus.rinc  = r;
        do_r = r && (exp_q.size() != 0);
        do_w = w && (exp_q.size() != DEPTH);
        if (do_r) begin
            check({tag, "_pop"}, 32'(bus.rdata), 32'(exp_q[0]));
        end
        @(posedge clk);
        if (do_r) void'(exp_q.pop_front());
        if (do_w) begin
            exp_q.push_back(d);
            wr_count++;
        end
        @(negedge clk);
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        check_flags(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.winc  = 1'b0;
        bus.rinc  = 1'b0;
        bus.wdata = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check("reset_rempty", 32'(bus.rempty), 32'd1);
        check("reset_wfull",  32'(bus.wfull),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fall-through from empty: head visible the cycle after the write, no rinc.
        step(1'b1, DSIZE'('h15), 1'b0, "ft");
        check("ft_rdata", 32'(bus.rdata), 32'h15);
        step(1'b0, '0, 1'b1, "ft_pop");

        // Fill to full, then an overflow write that must be dropped.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, DSIZE'(i), 1'b0, "fill");
        check("fill_wfull", 32'(bus.wfull), 32'd1);
        step(1'b1, DSIZE'('h3F), 1'b0, "ovf");
        check("ovf_head", 32'(bus.rdata), 32'h01);

        // Drain in order, then an underflow pop that must not move the pointers.
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain");
        check("drain_rempty", 32'(bus.rempty), 32'd1);
        step(1'b0, '0, 1'b1, "udf");
        step(1'b1, DSIZE'('h0B), 1'b0, "udf_w");
        check("udf_w_rdata", 32'(bus.rdata), 32'h0B);
        step(1'b0, '0, 1'b1, "udf_r");

        // Simultaneous push/pop at occupancy 8, then at full.
        for (int i = 0; i < 8; i++) step(1'b1, DSIZE'(i + 'h20), 1'b0, "mid_fill");
        for (int i = 0; i < 10; i++) step(1'b1, DSIZE'($urandom), 1'b1, "simul");
        for (int i = 0; i < 8; i++) step(1'b1, DSIZE'(i + 'h30), 1'b0, "top_fill");
        check("top_wfull", 32'(bus.wfull), 32'd1);
        step(1'b1, DSIZE'('h3E), 1'b1, "full_rw");
        check("full_rw_wfull", 32'(bus.wfull), 32'd0);
        for (int i = 0; i < DEPTH && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1, "drain2");
        check("drain2_rempty", 32'(bus.rempty), 32'd1);

        // Random traffic with alternating write-heavy/read-heavy phases.
        wr_count = 0;
        for (int i = 0; i < 300; i++) begin
            int unsigned pw, pr;
            pw = ((i / 40) % 2 == 0) ? 75 : 30;
            pr = ((i / 40) % 2 == 0) ? 30 : 75;
            step(1'($urandom_range(0, 99) < pw), DSIZE'($urandom),
                 1'($urandom_range(0, 99) < pr), "rand");
        end

        // Asynchronous reset mid-stream with five words stored.
        for (int i = 0; i < 5; i++) step(1'b1, DSIZE'(i + 'h10), 1'b0, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rempty", 32'(bus.rempty), 32'd1);
        check("mid_rst_wfull",  32'(bus.wfull),  32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, DSIZE'('h2A), 1'b0, "post_rst");
        check("post_rst_rdata", 32'(bus.rdata), 32'h2A);
        step(1'b0, '0, 1'b1, "post_rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
